// File: rtl/branch_sequencer.sv
// branch_sequencer: PC/branch sequencer with LUT-redirected branches, halt/start lifecycle and run watchdog.
module branch_sequencer #(
  parameter int PC_W    = 7,
  parameter int IDX_W   = 6,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt,
  input  logic             jump,
  input  logic             branch,
  input  logic             cond,
  input  logic [IDX_W-1:0] idx,
  input  logic [PC_W-1:0]  lut_target,
  output logic [IDX_W-1:0] lut_index,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_en,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             overflow,
  output logic [CNT_W-1:0] cycles
);
  typedef enum logic [1:0] {IDLE, RUN, LOOKUP, HALTED} state_t;
  state_t           r_state;
  logic [IDX_W-1:0] r_lut_index;
  logic [PC_W-1:0]  r_pc;
  logic             r_fetch_en, r_busy, r_done, r_timeout, r_overflow;
  logic [CNT_W-1:0] r_cycles;
  logic             w_taken, w_wdog, w_last;
  logic [CNT_W-1:0] w_cyc_next;
  assign w_taken    = jump | (branch & cond);
  // Fires on the last allowed busy cycle so the run ends after exactly TIMEOUT busy cycles.
  assign w_wdog     = (TIMEOUT != 0) && (r_cycles == CNT_W'(TIMEOUT - 1));
  assign w_last     = r_pc == '1;
  assign w_cyc_next = (r_cycles == '1) ? r_cycles : r_cycles + 1'b1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_lut_index <= '0;
      r_pc        <= '0;
      r_fetch_en  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_overflow  <= 1'b0;
      r_cycles    <= '0;
    end else begin
      case (r_state)
        RUN: begin
          r_cycles <= w_cyc_next;
          if (w_wdog || halt || (!w_taken && w_last)) begin
            r_state    <= HALTED;
            r_fetch_en <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_timeout  <= w_wdog;
            r_overflow <= !w_wdog && !halt;
          end else if (w_taken) begin
            r_state     <= LOOKUP;
            r_lut_index <= idx;
            r_fetch_en  <= 1'b0;
          end else begin
            r_pc <= r_pc + 1'b1;
          end
        end
        LOOKUP: begin
          r_cycles <= w_cyc_next;
          if (w_wdog) begin
            r_state   <= HALTED;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
          end else begin
            r_state    <= RUN;
            r_pc       <= lut_target;
            r_fetch_en <= 1'b1;
          end
        end
        default: begin
          if (start) begin
            r_state    <= RUN;
            r_pc       <= '0;
            r_cycles   <= '0;
            r_fetch_en <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_overflow <= 1'b0;
          end
        end
      endcase
    end
  end
  assign lut_index = r_lut_index;
  assign pc        = r_pc;
  assign fetch_en  = r_fetch_en;
  assign busy      = r_busy;
  assign done      = r_done;
  assign timeout   = r_timeout;
  assign overflow  = r_overflow;
  assign cycles    = r_cycles;
endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: directed checks of sequencing, branches, halt, watchdog, overflow and reset.
module tb_branch_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, halt = 1'b0, jump = 1'b0, branch = 1'b0, cond = 1'b0;
  logic [5:0]  idx = '0;
  logic [5:0]  lut_index0, lut_index1;
  logic [6:0]  lut_target0, lut_target1, pc0, pc1;
  logic        fetch_en0, busy0, done0, timeout0, overflow0;
  logic        fetch_en1, busy1, done1, timeout1, overflow1;
  logic [15:0] cycles0, cycles1;
  int          n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [6:0] lut(input logic [5:0] i);
    case (i)
      6'd3:    return 7'd30;
      6'd5:    return 7'd33;
      6'd6:    return 7'd28;
      6'd7:    return 7'd40;
      default: return 7'd0;
    endcase
  endfunction
  assign lut_target0 = lut(lut_index0);
  assign lut_target1 = lut(lut_index1);

  branch_sequencer #(.TIMEOUT(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .jump(jump), .branch(branch),
    .cond(cond), .idx(idx), .lut_target(lut_target0), .lut_index(lut_index0), .pc(pc0),
    .fetch_en(fetch_en0), .busy(busy0), .done(done0), .timeout(timeout0),
    .overflow(overflow0), .cycles(cycles0));

  branch_sequencer #(.TIMEOUT(10)) dut1 (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .jump(jump), .branch(branch),
    .cond(cond), .idx(idx), .lut_target(lut_target1), .lut_index(lut_index1), .pc(pc1),
    .fetch_en(fetch_en1), .busy(busy1), .done(done1), .timeout(timeout1),
    .overflow(overflow1), .cycles(cycles1));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic launch;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic end_run;
    halt = 1'b1;
    tick();
    halt = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    check("rst_pc", pc0, 0);
    check("rst_idx", lut_index0, 0);
    check("rst_cyc", cycles0, 0);
    check("rst_busy", busy0, 0);
    check("rst_fetch", fetch_en0, 0);
    check("rst_done", done0, 0);
    reset = 1'b0;
    tick();
    check("idle_hold", busy0, 0);

    // straight-line run halted at pc 5
    launch();
    for (int p = 0; p <= 5; p++) begin
      check("seq_pc", pc0, p);
      check("seq_fetch", fetch_en0, 1);
      halt = (p == 5);
      tick();
    end
    halt = 1'b0;
    check("halt_done", done0, 1);
    check("halt_pc", pc0, 5);
    check("halt_cyc", cycles0, 6);
    check("halt_busy", busy0, 0);
    check("halt_fetch", fetch_en0, 0);
    tick();
    check("halt_hold_pc", pc0, 5);
    check("halt_hold_cyc", cycles0, 6);

    // jump idx 3 at pc 2
    launch();
    check("j_start_done", done0, 0);
    tick();
    tick();
    check("j_pc2", pc0, 2);
    jump = 1'b1; idx = 6'd3;
    tick();
    jump = 1'b0;
    check("j_idx", lut_index0, 3);
    check("j_bubble_fetch", fetch_en0, 0);
    check("j_bubble_busy", busy0, 1);
    check("j_bubble_pc", pc0, 2);
    check("j_cyc1", cycles0, 3);
    tick();
    check("j_target", pc0, 30);
    check("j_fetch", fetch_en0, 1);
    check("j_cyc2", cycles0, 4);
    end_run();

    // conditional branch not taken, then taken
    launch();
    for (int i = 0; i < 4; i++) tick();
    check("b_pc4", pc0, 4);
    branch = 1'b1; idx = 6'd6; cond = 1'b0;
    tick();
    check("bnt_pc", pc0, 5);
    check("bnt_fetch", fetch_en0, 1);
    cond = 1'b1;
    tick();
    branch = 1'b0; cond = 1'b0;
    check("bt_bubble", fetch_en0, 0);
    check("bt_idx", lut_index0, 6);
    tick();
    check("bt_pc", pc0, 28);
    check("bt_fetch", fetch_en0, 1);
    end_run();

    // watchdog on self-loop at 33 (dut1, TIMEOUT=10)
    launch();
    jump = 1'b1; idx = 6'd5;
    for (int i = 0; i < 9; i++) tick();
    check("wd_busy9", busy1, 1);
    check("wd_done9", done1, 0);
    tick();
    jump = 1'b0;
    check("wd_done", done1, 1);
    check("wd_timeout", timeout1, 1);
    check("wd_cyc", cycles1, 10);
    check("wd_pc", pc1, 33);
    check("wd_busy", busy1, 0);
    check("wd_ovf", overflow1, 0);
    check("nowd_busy", busy0, 1);

    // asynchronous reset in LOOKUP
    reset = 1'b1;
    tick();
    reset = 1'b0;
    launch();
    jump = 1'b1; idx = 6'd7;
    tick();
    jump = 1'b0;
    check("rl_lookup", fetch_en0, 0);
    check("rl_idx", lut_index0, 7);
    #2 reset = 1'b1;
    #1;
    check("rl_pc", pc0, 0);
    check("rl_idx0", lut_index0, 0);
    check("rl_busy", busy0, 0);
    check("rl_fetch", fetch_en0, 0);
    check("rl_cyc", cycles0, 0);
    tick();
    reset = 1'b0;
    tick();
    check("rl_idle_pc", pc0, 0);
    check("rl_idle_busy", busy0, 0);

    // sequential run off the end of program space
    launch();
    check("ov_pc0", pc0, 0);
    tick();
    check("ov_pc1", pc0, 1);
    for (int i = 0; i < 200 && pc0 != 7'd127; i++) tick();
    check("ov_reach127", pc0, 127);
    check("ov_fetch127", fetch_en0, 1);
    tick();
    check("ov_done", done0, 1);
    check("ov_flag", overflow0, 1);
    check("ov_pc", pc0, 127);
    check("ov_timeout", timeout0, 0);
    check("ov_busy", busy0, 0);
    check("ov_cyc", cycles0, 128);
    launch();
    check("rs_pc", pc0, 0);
    check("rs_done", done0, 0);
    check("rs_ovf", overflow0, 0);
    check("rs_busy", busy0, 1);
    check("rs_cyc", cycles0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
